// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control sequencer for a small accumulator CPU.
// Walks FETCH -> LOAD -> DECODE -> EXEC per instruction, decodes the
// opcode into datapath controls, and counts retired instructions.
// Optional feature: define CPU_SEQ_SINGLE_STEP_EN to add the step input and a
// STEP_WAIT state that pauses after every executed instruction.
module cpu_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clb,
    input  logic [3:0]       opcode,
    input  logic             z,
    input  logic             c,
`ifdef CPU_SEQ_SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic             LoadIR,
    output logic             IncPC,
    output logic             LoadPC,
    output logic             SelPC,
    output logic             LoadAcc,
    output logic             LoadReg,
    output logic [1:0]       SelAcc,
    output logic [3:0]       SelALU,
    output logic [2:0]       cycle_status,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        StFetch    = 3'd0,
        StLoad     = 3'd1,
        StDecode   = 3'd2,
        StExec     = 3'd3,
`ifdef CPU_SEQ_SINGLE_STEP_EN
        StHalt     = 3'd4,
        StStepWait = 3'd5
`else
        StHalt     = 3'd4
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and retired-instruction counter, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!clb) begin
            state_q <= StFetch;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state sequencing; HLT parks in StHalt until reset.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:  state_d = StLoad;
            StLoad:   state_d = StDecode;
            StDecode: state_d = StExec;
            StExec: begin
                if (opcode == 4'hF) begin
                    state_d = StHalt;
                end else begin
`ifdef CPU_SEQ_SINGLE_STEP_EN
                    state_d = StStepWait;
`else
                    state_d = StFetch;
`endif
                end
            end
            StHalt:   state_d = StHalt;
`ifdef CPU_SEQ_SINGLE_STEP_EN
            StStepWait: begin
                if (step) begin
                    state_d = StFetch;
                end
            end
`endif
            default:  state_d = StFetch;
        endcase
    end

    // Every EXEC cycle retires one instruction, HLT included; wraps naturally.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StExec) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Control decode from state and opcode; all controls gated off while clb is low.
    always_comb begin
        LoadIR  = 1'b0;
        IncPC   = 1'b0;
        LoadPC  = 1'b0;
        SelPC   = 1'b0;
        LoadAcc = 1'b0;
        LoadReg = 1'b0;
        SelAcc  = 2'b00;
        SelALU  = 4'h0;
        if (clb) begin
            unique case (state_q)
                StLoad:   LoadIR = 1'b1;
                StDecode: IncPC  = 1'b1;
                StExec: begin
                    unique case (opcode)
                        4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
                            LoadAcc = 1'b1;
                            SelAcc  = 2'b00;
                            SelALU  = opcode;
                        end
                        4'h9: begin
                            LoadAcc = 1'b1;
                            SelAcc  = 2'b01;
                        end
                        4'hA: begin
                            LoadAcc = 1'b1;
                            SelAcc  = 2'b10;
                        end
                        4'hB: LoadReg = 1'b1;
                        4'hC: LoadPC  = 1'b1;
                        4'hD: begin
                            LoadPC = z;
                            SelPC  = z;
                        end
                        4'hE: begin
                            LoadPC = c;
                            SelPC  = c;
                        end
                        default: ;  // NOP and HLT drive nothing
                    endcase
                end
                default: ;  // FETCH, HALT, STEP_WAIT drive nothing
            endcase
        end
    end

    assign cycle_status = state_q;
    assign instr_cnt    = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer. The DUT is built with a 3-bit counter so
// that counter wrap is reached by running eight instructions.
module tb_cpu_sequencer;

    localparam int unsigned CW = 3;

    logic          clk;
    logic          clb;
    logic [3:0]    opcode;
    logic          z;
    logic          c;
`ifdef CPU_SEQ_SINGLE_STEP_EN
    logic          step;
`endif
    logic          LoadIR, IncPC, LoadPC, SelPC, LoadAcc, LoadReg;
    logic [1:0]    SelAcc;
    logic [3:0]    SelALU;
    logic [2:0]    cycle_status;
    logic [CW-1:0] instr_cnt;
    logic [11:0]   ctl;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [CW-1:0] exp_cnt;

    cpu_sequencer #(.CNT_W(CW)) dut (
        .clk          (clk),
        .clb          (clb),
        .opcode       (opcode),
        .z            (z),
        .c            (c),
`ifdef CPU_SEQ_SINGLE_STEP_EN
        .step         (step),
`endif
        .LoadIR       (LoadIR),
        .IncPC        (IncPC),
        .LoadPC       (LoadPC),
        .SelPC        (SelPC),
        .LoadAcc      (LoadAcc),
        .LoadReg      (LoadReg),
        .SelAcc       (SelAcc),
        .SelALU       (SelALU),
        .cycle_status (cycle_status),
        .instr_cnt    (instr_cnt)
    );

    // Packed view: LoadIR IncPC LoadPC SelPC LoadAcc LoadReg SelAcc[1:0] SelALU[3:0]
    assign ctl = {LoadIR, IncPC, LoadPC, SelPC, LoadAcc, LoadReg, SelAcc, SelALU};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH; leaves the DUT in FETCH (or HALT for HLT).
    task automatic run_instr(input logic [3:0] op, input logic zz, input logic cc,
                             input logic [11:0] exp_exec);
        opcode = op;
        z      = zz;
        c      = cc;
        #1;
        chk("fetch_state", 32'(cycle_status), 32'd0);
        chk("fetch_ctl", 32'(ctl), 32'h000);
        tick();
        chk("load_state", 32'(cycle_status), 32'd1);
        chk("load_ctl", 32'(ctl), 32'h800);
        tick();
        chk("decode_state", 32'(cycle_status), 32'd2);
        chk("decode_ctl", 32'(ctl), 32'h400);
        tick();
        chk("exec_state", 32'(cycle_status), 32'd3);
        chk("exec_ctl", 32'(ctl), 32'(exp_exec));
        tick();
        exp_cnt = exp_cnt + 1'b1;
        chk("retire_cnt", 32'(instr_cnt), 32'(exp_cnt));
        if (op == 4'hF) begin
            chk("halt_state", 32'(cycle_status), 32'd4);
        end else begin
`ifdef CPU_SEQ_SINGLE_STEP_EN
            chk("stepwait_state", 32'(cycle_status), 32'd5);
            chk("stepwait_ctl", 32'(ctl), 32'h000);
            step = 1'b1;
            tick();
            step = 1'b0;
`endif
            chk("next_fetch_state", 32'(cycle_status), 32'd0);
        end
    endtask

    initial begin
        clb     = 1'b0;
        opcode  = 4'h0;
        z       = 1'b0;
        c       = 1'b0;
        exp_cnt = '0;
`ifdef CPU_SEQ_SINGLE_STEP_EN
        step    = 1'b0;
`endif
        // Reset from power-up for two cycles
        tick();
        tick();
        chk("rst_state", 32'(cycle_status), 32'd0);
        chk("rst_ctl", 32'(ctl), 32'h000);
        chk("rst_cnt", 32'(instr_cnt), 32'd0);
        clb = 1'b1;

        run_instr(4'h9, 1'b0, 1'b0, 12'h090);  // LDI
        chk("ldi_cnt", 32'(instr_cnt), 32'd1);
        run_instr(4'h1, 1'b1, 1'b1, 12'h081);  // ADD, flags must not matter
        run_instr(4'hD, 1'b0, 1'b1, 12'h000);  // JZ not taken
        run_instr(4'hF, 1'b1, 1'b1, 12'h000);  // HLT as 4th instruction

        // HALT holds with counter frozen
        for (int i = 0; i < 12; i++) begin
            opcode = 4'(i);
            tick();
            chk("halt_hold_state", 32'(cycle_status), 32'd4);
            chk("halt_hold_ctl", 32'(ctl), 32'h000);
            chk("halt_hold_cnt", 32'(instr_cnt), 32'd4);
        end

        // Reset out of HALT
        clb = 1'b0;
        tick();
        chk("halt_rst_state", 32'(cycle_status), 32'd0);
        chk("halt_rst_cnt", 32'(instr_cnt), 32'd0);
        clb = 1'b1;
        exp_cnt = '0;

        // Eight instructions wrap the 3-bit counter back to 0
        run_instr(4'hD, 1'b1, 1'b0, 12'h300);  // JZ taken
        run_instr(4'hE, 1'b0, 1'b1, 12'h300);  // JC taken
        run_instr(4'hE, 1'b1, 1'b0, 12'h000);  // JC not taken
        run_instr(4'hA, 1'b0, 1'b0, 12'h0A0);  // LDR
        run_instr(4'hB, 1'b0, 1'b0, 12'h040);  // STR
        run_instr(4'hC, 1'b1, 1'b1, 12'h200);  // JMP
        run_instr(4'h0, 1'b1, 1'b1, 12'h000);  // NOP
        chk("cnt_all_ones", 32'(instr_cnt), 32'd7);
        run_instr(4'h8, 1'b0, 1'b0, 12'h088);  // SHR
        chk("cnt_wrap", 32'(instr_cnt), 32'd0);
        run_instr(4'h5, 1'b0, 1'b0, 12'h085);  // XOR

        // Reset asserted during EXEC of ADD
        opcode = 4'h1;
        tick();
        tick();
        tick();
        chk("midexec_state", 32'(cycle_status), 32'd3);
        chk("midexec_ctl_live", 32'(ctl), 32'h081);
        clb = 1'b0;
        #1;
        chk("midexec_ctl_gated", 32'(ctl), 32'h000);
        tick();
        chk("midexec_rst_state", 32'(cycle_status), 32'd0);
        chk("midexec_rst_cnt", 32'(instr_cnt), 32'd0);
        clb = 1'b1;
        exp_cnt = '0;

`ifdef CPU_SEQ_SINGLE_STEP_EN
        // Step pulse in FETCH is ignored
        opcode = 4'h2;
        step   = 1'b1;
        #1;
        chk("step_fetch_state", 32'(cycle_status), 32'd0);
        tick();
        step = 1'b0;
        chk("step_ignored_state", 32'(cycle_status), 32'd1);
        tick();
        tick();
        tick();
        chk("step_wait_entry", 32'(cycle_status), 32'd5);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("step_wait_hold", 32'(cycle_status), 32'd5);
        end
        chk("step_wait_cnt", 32'(instr_cnt), 32'd1);
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("step_release", 32'(cycle_status), 32'd0);
`else
        run_instr(4'h2, 1'b0, 1'b0, 12'h082);  // SUB
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
